// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding,
// requester count and a small index-to-one-hot helper.
package rr_mux_arbiter_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] idx2oh(input logic [1:0] idx);
        idx2oh      = '0;
        idx2oh[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// Existing single-bit 4:1 multiplexer; the arbiter instantiates one per data bit.
module four_to_one_mux (
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (sel)
            2'd0: y = d[0];
            2'd1: y = d[1];
            2'd2: y = d[2];
            2'd3: y = d[3];
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux datapath between four requesters,
// with a registered data word, valid flag and bounded hold time per grant.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   din,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [1:0]                 sel,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic                       busy
);

    localparam int              HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0]   HOLD_ONE = HW'(1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [1:0]           sel_q, sel_d;
    logic [1:0]           last_q, last_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0]     dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;

    logic [WIDTH-1:0]     mux_y;
    logic [NUM_REQ-1:0]   owner_oh;
    logic [NUM_REQ-1:0]   others;
    logic                 owner_req;
    logic                 rel;
    logic [1:0]           pick;

    // First set bit searching last+1, last+2, last+3, last (2-bit wrap).
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                           input logic [1:0]         last);
        logic [1:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    for (genvar b = 0; b < WIDTH; b++) begin : g_mux
        four_to_one_mux u_mux (
            .d   ({din[3*WIDTH+b], din[2*WIDTH+b], din[WIDTH+b], din[b]}),
            .sel (sel_q),
            .y   (mux_y[b])
        );
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        sel_d        = sel_q;
        last_d       = last_q;
        hold_cnt_d   = hold_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        owner_oh     = idx2oh(sel_q);
        others       = req & ~owner_oh;
        owner_req    = |(req & owner_oh);
        rel          = 1'b0;
        pick         = 2'd0;

        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    pick       = rr_pick(req, last_q);
                    state_d    = ST_GRANT;
                    gnt_d      = idx2oh(pick);
                    sel_d      = pick;
                    hold_cnt_d = HOLD_ONE;
                end
            end
            ST_GRANT: begin
                if (owner_req) begin
                    dout_d       = mux_y;
                    dout_valid_d = 1'b1;
                end
                // A forced hand-over still moves the old owner's word this edge.
                rel = !owner_req || ((hold_cnt_q == HOLD_MAX) && (|others));
                if (rel) begin
                    last_d = sel_q;
                    if (|others) begin
                        pick       = rr_pick(others, sel_q);
                        gnt_d      = idx2oh(pick);
                        sel_d      = pick;
                        hold_cnt_d = HOLD_ONE;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            sel_q        <= 2'd0;
            last_q       <= 2'd3;
            hold_cnt_q   <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            hold_cnt_q   <= hold_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign gnt        = gnt_q;
    assign sel        = sel_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == ST_GRANT);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (WIDTH=4, MAX_HOLD=4); outputs are
// sampled on the falling edge, inputs driven right after it.
module tb_rr_mux_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [3:0]  dout;
    logic        dout_valid;
    logic        busy;

    int checks = 0;
    int passed = 0;

    rr_mux_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] slice_of(input logic [15:0] d, input int i);
        return d[i*4 +: 4];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b0000; din = 16'h0000;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else passed++;
        checks++; if (sel !== 2'd0) $display("FAIL reset_sel: got %0d want 0", sel); else passed++;
        checks++; if (dout !== 4'h0) $display("FAIL reset_dout: got %h want 0", dout); else passed++;
        checks++; if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dout_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        rst_n = 1'b1; req = 4'b1111; din = 16'hDCBA;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) $display("FAIL first_gnt: got %b want 0001", gnt); else passed++;
        checks++; if (sel !== 2'd0) $display("FAIL first_sel: got %0d want 0", sel); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL first_busy: got %b want 1", busy); else passed++;
        @(negedge clk);
        checks++; if (dout !== 4'hA || dout_valid !== 1'b1)
            $display("FAIL pre_abort_data: got %h/%b want a/1", dout, dout_valid); else passed++;
        // asynchronous abort between clock edges
        #2 rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000) $display("FAIL abort_gnt: got %b want 0000", gnt); else passed++;
        checks++; if (dout !== 4'h0) $display("FAIL abort_dout: got %h want 0", dout); else passed++;
        checks++; if (dout_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", dout_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req = 4'b0100; din = 16'h0A00;
        @(negedge clk);
        checks++; if (gnt !== 4'b0100 || sel !== 2'd2)
            $display("FAIL single_grant: got %b/%0d want 0100/2", gnt, sel); else passed++;
        checks++; if (dout_valid !== 1'b0) $display("FAIL single_first_valid: got %b want 0", dout_valid); else passed++;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (gnt !== 4'b0100) $display("FAIL single_hold c%0d: got %b want 0100", c, gnt); else passed++;
            checks++; if (dout !== 4'hA || dout_valid !== 1'b1)
                $display("FAIL single_data c%0d: got %h/%b want a/1", c, dout, dout_valid); else passed++;
        end
        req = 4'b0000;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0)
            $display("FAIL single_idle: got %b/%b want 0000/0", gnt, busy); else passed++;
        checks++; if (dout_valid !== 1'b0 || dout !== 4'hA)
            $display("FAIL single_drop_data: got %h/%b want a/0", dout, dout_valid); else passed++;
    endtask

    task automatic test_fairness();
        logic [3:0] exp_gnt;
        logic [3:0] exp_dout;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        req = 4'b1111; din = 16'hDCBA;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            exp_gnt = 4'b0001 << ((k / 4) % 4);
            checks++; if (gnt !== exp_gnt || busy !== 1'b1)
                $display("FAIL fair_gnt k%0d: got %b/%b want %b/1", k, gnt, busy, exp_gnt); else passed++;
            if (k >= 1) begin
                exp_dout = slice_of(din, ((k - 1) / 4) % 4);
                checks++; if (dout !== exp_dout || dout_valid !== 1'b1)
                    $display("FAIL fair_dout k%0d: got %h/%b want %h/1", k, dout, dout_valid, exp_dout); else passed++;
            end
        end
        req = 4'b0000;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0)
            $display("FAIL fair_idle: got %b/%b want 0000/0", gnt, busy); else passed++;
    endtask

    task automatic test_early_release();
        req = 4'b1010; din = 16'hDCBA;
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) $display("FAIL early_first: got %b want 0010", gnt); else passed++;
        @(negedge clk);
        checks++; if (gnt !== 4'b0010 || dout !== 4'hB || dout_valid !== 1'b1)
            $display("FAIL early_second: got %b/%h/%b want 0010/b/1", gnt, dout, dout_valid); else passed++;
        req = 4'b1000;
        @(negedge clk);
        checks++; if (gnt !== 4'b1000 || sel !== 2'd3 || busy !== 1'b1)
            $display("FAIL early_switch: got %b/%0d/%b want 1000/3/1", gnt, sel, busy); else passed++;
        checks++; if (dout_valid !== 1'b0 || dout !== 4'hB)
            $display("FAIL early_gap_data: got %h/%b want b/0", dout, dout_valid); else passed++;
        req = 4'b0000;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) $display("FAIL early_idle: got %b want 0000", gnt); else passed++;
    endtask

    task automatic test_wrap();
        req = 4'b1001;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001 || sel !== 2'd0)
            $display("FAIL wrap_first: got %b/%0d want 0001/0", gnt, sel); else passed++;
        req = 4'b1000;
        @(negedge clk);
        checks++; if (gnt !== 4'b1000 || sel !== 2'd3 || busy !== 1'b1)
            $display("FAIL wrap_next: got %b/%0d/%b want 1000/3/1", gnt, sel, busy); else passed++;
        req = 4'b0000;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0)
            $display("FAIL wrap_idle: got %b/%b want 0000/0", gnt, busy); else passed++;
    endtask

    task automatic test_data_routing();
        logic [3:0] exp_gnt;
        logic [3:0] exp_d;
        din = 16'hDCBA;
        for (int i = 0; i < 4; i++) begin
            req = 4'b0001 << i;
            exp_gnt = 4'b0001 << i;
            @(negedge clk);
            checks++; if (gnt !== exp_gnt || dout_valid !== 1'b0)
                $display("FAIL route_grant r%0d: got %b/%b want %b/0", i, gnt, dout_valid, exp_gnt); else passed++;
            if (i > 0) begin
                exp_d = slice_of(din, i - 1);
                checks++; if (dout !== exp_d)
                    $display("FAIL route_hold r%0d: got %h want %h", i, dout, exp_d); else passed++;
            end
            @(negedge clk);
            exp_d = slice_of(din, i);
            checks++; if (dout !== exp_d || dout_valid !== 1'b1)
                $display("FAIL route_data r%0d: got %h/%b want %h/1", i, dout, dout_valid, exp_d); else passed++;
        end
        req = 4'b0000;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000 || dout_valid !== 1'b0 || dout !== 4'hD)
            $display("FAIL route_idle: got %b/%b/%h want 0000/0/d", gnt, dout_valid, dout); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_early_release();
        test_wrap();
        test_data_routing();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 multiplexer datapath between four requesters.
- Grants one requester at a time and drives the mux select from that grant.
- Registers the selected data word with a valid flag.
- Sits in front of the existing 4:1 mux. Turns the free-running select sweep into a request/grant-controlled shared channel.

Parameters:
WIDTH, 4, data width of each requester input and of dout
MAX_HOLD, 4, max consecutive granted cycles before a forced hand-over while another requester waits (>=1)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request per requester; bit i = requester i
din  input  4*WIDTH  packed data; requester i at din[i*WIDTH +: WIDTH]
gnt  output  4  one-hot grant (all-zero when idle), registered
sel  output  2  mux select = index of granted requester, registered
dout  output  WIDTH  registered mux output
dout_valid  output  1  dout holds a word transferred this cycle
busy  output  1  high in GRANT state

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: gnt=0, sel=0, dout=0, dout_valid=0, busy=0.
  - Internal: state=IDLE, last=3 (requester 0 is first priority), hold_cnt=0.
  - Reset mid-grant aborts the grant immediately; no partial transfer completes.
- Round-robin pick:
  - Search order is last+1, last+2, last+3, last (mod 4). First set req bit wins.
  - 2-bit wrap: last=3 searches 0,1,2,3.
- IDLE:
  - At an edge with req!=0: the pick is registered into gnt/sel, state goes to GRANT, hold_cnt=1.
  - Grant is visible 1 cycle after req is sampled.
  - req==0: stay IDLE, gnt=0.
- GRANT, evaluated at each edge with owner o=sel:
  - Transfer: if req[o]=1, then dout<=din slice o and dout_valid<=1. Otherwise dout_valid<=0 and dout holds.
  - Release conditions:
    - (a) req[o]=0.
    - (b) hold_cnt==MAX_HOLD and some other req[j]=1, j!=o.
  - On release:
    - last<=o.
    - If any req bit other than o is set, switch directly to the next round-robin winner (excluding o), with no idle bubble, and set hold_cnt=1.
    - Otherwise go to IDLE with gnt=0.
  - Under (b), the word sampled at that edge is still transferred (last beat of the old owner).
  - No release: hold_cnt increments and saturates at MAX_HOLD. A sole requester keeps the grant indefinitely.
  - A requester that drops and re-raises req while another holds the grant waits its round-robin turn.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt[sel]=1 whenever busy=1.
  - dout_valid=1 only in cycles after an edge where busy=1 and req[sel]=1.
  - Throughput: 1 word/cycle while the owner holds req. Latency din→dout is 1 cycle once granted.
- Simultaneous events:
  - All four requests rising together in IDLE after reset → requester 0 is granted first.
  - Owner dropping req and hitting MAX_HOLD in the same edge is treated as release (a).

Decomposition:
- Shared package holds:
  - State encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Requester count constant NUM_REQ=4.
- One natural sub-module: the existing four_to_one_mux, instantiated once per data bit (WIDTH copies) with sel driven from the arbiter.
  - Its output feeds the dout register.
- Round-robin pick logic stays inline as a combinational function.

Test Plan:
- Reset: drive rst_n=0 mid-grant for 1 ns (asynchronous, no clock edge) → gnt=0, dout=0, dout_valid=0, busy=0 immediately. After release, req=4'b1111 → gnt=4'b0001, sel=0.
- Single requester: req=4'b0100, din slice2=4'hA for 10 cycles → gnt=4'b0100 throughout, no forced hand-over. dout=4'hA with dout_valid=1 from 2nd granted edge. After req drops → IDLE next cycle.
- Fairness (MAX_HOLD=4): req=4'b1111 constant → gnt sequence 0001,0010,0100,1000,0001, each held exactly 4 cycles, no idle gap.
- Early release: owner 1 drops req after 2 cycles while req[3]=1 → gnt switches 0010→1000 at next edge, last=1.
- Wrap-around: last=3, req=4'b1001 → requester 0 granted before 3. After requester 0 releases → requester 3 granted.
- Data routing: WIDTH=4, din=16'hDCBA, grant each requester in turn → dout = A,B,C,D respectively, dout_valid deasserted in any cycle where owner req=0.
